mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of both requester ports and the memory port.
REQ-002 Parameter DATA_W, default 32, data width of both requester ports and the memory port.
REQ-003 Parameter TIMEOUT, default 255, maximum BUSY cycles without mem_ready before abort; counter width SHALL be 8 bits, so the legal range is 1..255.
REQ-004 iCLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 iRST_n  input  1  synchronous, active-low reset, sampled on the rising edge of iCLK.
REQ-006 mX_addr  input  ADDR_W  requester X address (X = 0, 1; 0 = instruction cache, 1 = data cache).
REQ-007 mX_data  input  DATA_W  requester X write data.
REQ-008 mX_MemRead / mX_MemWrite  input  1 each  requester X read / write request levels.
REQ-009 mX_data_out  output  DATA_W  read data returned to requester X.
REQ-010 mX_ready  output  1  one-cycle completion pulse to requester X.
REQ-011 mem_addr / mem_data  output  ADDR_W / DATA_W  memory request address / write data.
REQ-012 mem_MemRead / mem_MemWrite  output  1 each  memory request strobes.
REQ-013 mem_data_in  input  DATA_W  memory read data.
REQ-014 mem_ready  input  1  memory completion indication.
REQ-015 timeout_err  output  1  sticky flag: a memory transaction was aborted by timeout.

Function
REQ-016 Requester X SHALL be requesting when mX_MemRead | mX_MemWrite = 1; requesters SHALL hold the request and its address/data stable until mX_ready is seen.
REQ-017 If mX_MemRead and mX_MemWrite are both 1, the arbiter SHALL treat the request as a write only.
REQ-018 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-019 In IDLE with exactly one requester active, the arbiter SHALL grant that requester.
REQ-020 In IDLE with both requesters active, the arbiter SHALL grant the requester other than last_grant (round-robin).
REQ-021 last_grant SHALL update on every grant.
REQ-022 On grant, the arbiter SHALL latch the granted requester's address, data and strobe into registers, then enter BUSY.
REQ-023 The mem_* outputs SHALL come only from the REQ-022 registers, so mem strobes assert the cycle after the request is sampled in IDLE.
REQ-024 In BUSY, mem outputs SHALL hold their values.
REQ-025 In BUSY, requester inputs SHALL be ignored.
REQ-026 In BUSY with mem_ready = 1, the arbiter SHALL, on that edge, capture mem_data_in into the granted mX_data_out (reads only; writes leave mX_data_out unchanged).
REQ-027 On the same edge as REQ-026, the arbiter SHALL deassert both mem strobes and enter DONE.
REQ-028 In DONE, the granted mX_ready SHALL be 1 for exactly one cycle.
REQ-029 No arbitration SHALL occur in DONE.
REQ-030 The next state after DONE SHALL be IDLE.
REQ-031 Requesters SHALL drop or replace the request on the edge where mX_ready is sampled high.
REQ-032 A request already active in IDLE after DONE SHALL be treated as new, giving a minimum of 3 cycles per transaction (IDLE, BUSY, DONE).
REQ-033 The non-granted requester's mX_ready SHALL stay 0 and its mX_data_out SHALL be unchanged.
REQ-034 The timeout counter SHALL clear on grant.
REQ-035 The timeout counter SHALL increment each BUSY cycle with mem_ready = 0, saturating at 255.
REQ-036 When the counter equals TIMEOUT in BUSY with mem_ready = 0, the arbiter SHALL deassert the strobes, set timeout_err, write 0 to the granted mX_data_out (reads only), and enter DONE.
REQ-037 mem_ready in IDLE or DONE SHALL be ignored.
REQ-038 timeout_err SHALL clear only by reset.

Reset
REQ-039 With iRST_n = 0 at a rising edge, the block SHALL set: state IDLE, last_grant = 1, counter 0, all mem_* outputs 0, mX_ready 0, mX_data_out 0, timeout_err 0.
REQ-040 Reset mid-BUSY or mid-DONE SHALL abandon the transaction with no mX_ready pulse, and strobes SHALL be 0 after that edge.
REQ-041 The first grant after reset SHALL go to requester 0 when both requesters are active.

Verification
REQ-042 Single read: m0 read 0x40, mem_ready after 2 BUSY cycles with data 0xDEADBEEF -> mem_MemRead=1 and mem_addr=0x40 from cycle 1; m0_ready pulses once; m0_data_out=0xDEADBEEF; m1_ready stays 0.
REQ-043 Simultaneous: after reset, m0 read 0x10 and m1 write 0x20/0x55 held continuously -> grants m0, m1, m0, m1, with each mem_addr matching its requester.
REQ-044 Write: m1 write 0x80 data 0x12345678 -> mem_MemWrite=1, mem_data=0x12345678; m1_ready pulse; m1_data_out unchanged.
REQ-045 Timeout: TIMEOUT=4, m0 read, mem_ready held 0 -> strobe drops after 4 BUSY cycles; m0_ready pulses; m0_data_out=0; timeout_err stays 1 until reset.
REQ-046 Reset during BUSY: iRST_n=0 for one edge -> all outputs 0 next cycle, no mX_ready pulse, next simultaneous request grants m0.
REQ-047 Both strobes: m0 MemRead=MemWrite=1 -> only mem_MemWrite asserted.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Brief    : Bundle of requester-side and memory-side signals of mem_arbiter.
//             The slave modport is the arbiter's view. The master modport is
//             the view of the surrounding system, that is the caches and the
//             memory model.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // requester 0 (instruction cache)
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_data;
   logic              m0_MemRead;
   logic              m0_MemWrite;
   logic [DATA_W-1:0] m0_data_out;
   logic              m0_ready;
   // requester 1 (data cache)
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_data;
   logic              m1_MemRead;
   logic              m1_MemWrite;
   logic [DATA_W-1:0] m1_data_out;
   logic              m1_ready;
   // memory port
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_MemRead;
   logic              mem_MemWrite;
   logic [DATA_W-1:0] mem_data_in;
   logic              mem_ready;
   // status
   logic              timeout_err;

   modport slave (
      input  m0_addr, m0_data, m0_MemRead, m0_MemWrite,
      output m0_data_out, m0_ready,
      input  m1_addr, m1_data, m1_MemRead, m1_MemWrite,
      output m1_data_out, m1_ready,
      output mem_addr, mem_data, mem_MemRead, mem_MemWrite,
      input  mem_data_in, mem_ready,
      output timeout_err
   );

   modport master (
      output m0_addr, m0_data, m0_MemRead, m0_MemWrite,
      input  m0_data_out, m0_ready,
      output m1_addr, m1_data, m1_MemRead, m1_MemWrite,
      input  m1_data_out, m1_ready,
      input  mem_addr, mem_data, mem_MemRead, mem_MemWrite,
      output mem_data_in, mem_ready,
      input  timeout_err
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Two-requester round-robin memory arbiter with a BUSY timeout.
//             A transaction runs through IDLE -> BUSY -> DONE. The memory
//             request is driven only from registers latched at grant time.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  wire logic     iCLK,
   input  wire logic     iRST_n,
   mem_arbiter_if.slave  bus
);

   localparam logic [7:0] c_timeout = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_last_grant;   // also selects the requester being served
   logic [7:0]        r_cnt;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_data;
   logic              r_mem_read;
   logic              r_mem_write;
   logic [DATA_W-1:0] r_dout0;
   logic [DATA_W-1:0] r_dout1;
   logic              r_ready0;
   logic              r_ready1;
   logic              r_timeout_err;

   logic              w_req0;
   logic              w_req1;
   logic              w_pick1;
   logic [7:0]        w_cnt_inc;
   logic              w_expire;

   // Request detection, round-robin pick and saturating timeout increment
   always_comb begin
      w_req0    = bus.m0_MemRead | bus.m0_MemWrite;
      w_req1    = bus.m1_MemRead | bus.m1_MemWrite;
      // Requester 1 wins when it is alone, or when both request and 0 was served last.
      w_pick1   = w_req1 & (~w_req0 | ~r_last_grant);
      w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
      // Abort on the BUSY cycle that brings the count of silent cycles up to TIMEOUT.
      w_expire  = (w_cnt_inc == c_timeout);
   end

   // Arbitration FSM with all outputs registered
   always_ff @(posedge iCLK) begin
      if (!iRST_n) begin
         r_state       <= IDLE;
         r_last_grant  <= 1'b1;
         r_cnt         <= 8'd0;
         r_mem_addr    <= '0;
         r_mem_data    <= '0;
         r_mem_read    <= 1'b0;
         r_mem_write   <= 1'b0;
         r_dout0       <= '0;
         r_dout1       <= '0;
         r_ready0      <= 1'b0;
         r_ready1      <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_ready0 <= 1'b0;
         r_ready1 <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req0 | w_req1) begin
                  r_last_grant <= w_pick1;
                  r_cnt        <= 8'd0;
                  r_mem_addr   <= w_pick1 ? bus.m1_addr : bus.m0_addr;
                  r_mem_data   <= w_pick1 ? bus.m1_data : bus.m0_data;
                  // A simultaneous read and write is treated as a write.
                  r_mem_write  <= w_pick1 ? bus.m1_MemWrite : bus.m0_MemWrite;
                  r_mem_read   <= w_pick1 ? (bus.m1_MemRead & ~bus.m1_MemWrite)
                                          : (bus.m0_MemRead & ~bus.m0_MemWrite);
                  r_state      <= BUSY;
               end
            end
            BUSY: begin
               if (bus.mem_ready) begin
                  if (r_mem_read) begin
                     if (r_last_grant) r_dout1 <= bus.mem_data_in;
                     else              r_dout0 <= bus.mem_data_in;
                  end
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
                  r_ready0    <= ~r_last_grant;
                  r_ready1    <= r_last_grant;
                  r_state     <= DONE;
               end else begin
                  r_cnt <= w_cnt_inc;
                  if (w_expire) begin
                     if (r_mem_read) begin
                        if (r_last_grant) r_dout1 <= '0;
                        else              r_dout0 <= '0;
                     end
                     r_mem_read    <= 1'b0;
                     r_mem_write   <= 1'b0;
                     r_timeout_err <= 1'b1;
                     r_ready0      <= ~r_last_grant;
                     r_ready1      <= r_last_grant;
                     r_state       <= DONE;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_addr     = r_mem_addr;
   assign bus.mem_data     = r_mem_data;
   assign bus.mem_MemRead  = r_mem_read;
   assign bus.mem_MemWrite = r_mem_write;
   assign bus.m0_data_out  = r_dout0;
   assign bus.m1_data_out  = r_dout1;
   assign bus.m0_ready     = r_ready0;
   assign bus.m1_ready     = r_ready1;
   assign bus.timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Directed self-checking bench for mem_arbiter (TIMEOUT = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   logic iCLK;
   logic iRST_n;
   int   n_cmp;
   int   n_err;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .iCLK   (iCLK),
      .iRST_n (iRST_n),
      .bus    (bus.slave)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // advance one rising edge, then settle before sampling
   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic drop_all();
      bus.m0_MemRead  = 1'b0;
      bus.m0_MemWrite = 1'b0;
      bus.m1_MemRead  = 1'b0;
      bus.m1_MemWrite = 1'b0;
      bus.mem_ready   = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      iRST_n          = 1'b0;
      bus.m0_addr     = '0;
      bus.m0_data     = '0;
      bus.m1_addr     = '0;
      bus.m1_data     = '0;
      bus.mem_data_in = '0;
      drop_all();

      // ---------------- reset state
      tick();
      tick();
      chk("rst_rd",    bus.mem_MemRead,  0);
      chk("rst_wr",    bus.mem_MemWrite, 0);
      chk("rst_addr",  bus.mem_addr,     0);
      chk("rst_rdy0",  bus.m0_ready,     0);
      chk("rst_rdy1",  bus.m1_ready,     0);
      chk("rst_dout0", bus.m0_data_out,  0);
      chk("rst_terr",  bus.timeout_err,  0);
      iRST_n = 1'b1;

      // ---------------- single read, data after two BUSY cycles
      bus.m0_addr    = 32'h40;
      bus.m0_MemRead = 1'b1;
      tick();
      chk("rd_strobe1", bus.mem_MemRead, 1);
      chk("rd_addr",    bus.mem_addr,    32'h40);
      tick();
      chk("rd_strobe2", bus.mem_MemRead, 1);
      chk("rd_rdy_early", bus.m0_ready,  0);
      bus.mem_ready   = 1'b1;
      bus.mem_data_in = 32'hDEADBEEF;
      tick();
      chk("rd_rdy0",   bus.m0_ready,     1);
      chk("rd_rdy1",   bus.m1_ready,     0);
      chk("rd_dout0",  bus.m0_data_out,  32'hDEADBEEF);
      chk("rd_strobe_off", bus.mem_MemRead, 0);
      drop_all();
      tick();
      chk("rd_rdy0_once", bus.m0_ready,  0);

      // ---------------- round robin after reset, both held continuously
      iRST_n = 1'b0;
      tick();
      iRST_n = 1'b1;
      bus.m0_addr     = 32'h10;
      bus.m0_MemRead  = 1'b1;
      bus.m1_addr     = 32'h20;
      bus.m1_data     = 32'h55;
      bus.m1_MemWrite = 1'b1;
      bus.mem_ready   = 1'b1;
      bus.mem_data_in = 32'hA5A5A5A5;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("rr%0d_addr", k), bus.mem_addr, (k % 2 == 0) ? 32'h10 : 32'h20);
         chk($sformatf("rr%0d_rd", k),   bus.mem_MemRead,  (k % 2 == 0) ? 1 : 0);
         chk($sformatf("rr%0d_wr", k),   bus.mem_MemWrite, (k % 2 == 0) ? 0 : 1);
         tick();
         chk($sformatf("rr%0d_rdy0", k), bus.m0_ready, (k % 2 == 0) ? 1 : 0);
         chk($sformatf("rr%0d_rdy1", k), bus.m1_ready, (k % 2 == 0) ? 0 : 1);
         tick();
      end
      chk("rr_dout0", bus.m0_data_out, 32'hA5A5A5A5);
      chk("rr_dout1", bus.m1_data_out, 0);
      drop_all();

      // ---------------- write from requester 1
      bus.m1_addr     = 32'h80;
      bus.m1_data     = 32'h12345678;
      bus.m1_MemWrite = 1'b1;
      tick();
      chk("wr_strobe", bus.mem_MemWrite, 1);
      chk("wr_rd_off", bus.mem_MemRead,  0);
      chk("wr_addr",   bus.mem_addr,     32'h80);
      chk("wr_data",   bus.mem_data,     32'h12345678);
      bus.mem_ready   = 1'b1;
      bus.mem_data_in = 32'h99999999;
      tick();
      chk("wr_rdy1",   bus.m1_ready,     1);
      chk("wr_rdy0",   bus.m0_ready,     0);
      chk("wr_dout1",  bus.m1_data_out,  0);
      chk("wr_strobe_off", bus.mem_MemWrite, 0);
      drop_all();
      tick();

      // ---------------- read and write together from requester 0
      bus.m0_addr     = 32'h90;
      bus.m0_data     = 32'hCAFE;
      bus.m0_MemRead  = 1'b1;
      bus.m0_MemWrite = 1'b1;
      tick();
      chk("both_wr", bus.mem_MemWrite, 1);
      chk("both_rd", bus.mem_MemRead,  0);
      bus.mem_ready   = 1'b1;
      bus.mem_data_in = 32'h11111111;
      tick();
      chk("both_rdy0",  bus.m0_ready,    1);
      chk("both_dout0", bus.m0_data_out, 32'hA5A5A5A5);
      drop_all();
      tick();

      // ---------------- timeout with TIMEOUT = 4
      bus.m0_addr    = 32'h44;
      bus.m0_MemRead = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("to_busy%0d", k), bus.mem_MemRead, 1);
      end
      chk("to_terr_early", bus.timeout_err, 0);
      tick();
      chk("to_strobe_off", bus.mem_MemRead,  0);
      chk("to_rdy0",       bus.m0_ready,     1);
      chk("to_dout0",      bus.m0_data_out,  0);
      chk("to_terr",       bus.timeout_err,  1);
      drop_all();
      tick();
      chk("to_rdy0_once",  bus.m0_ready,     0);
      tick();
      chk("to_terr_sticky", bus.timeout_err, 1);

      // ---------------- reset in BUSY (last grant was 0, so 1 is served first)
      bus.m0_addr     = 32'h10;
      bus.m0_MemRead  = 1'b1;
      bus.m1_addr     = 32'h20;
      bus.m1_MemWrite = 1'b1;
      tick();
      chk("rb_grant1", bus.mem_MemWrite, 1);
      iRST_n = 1'b0;
      tick();
      iRST_n = 1'b1;
      chk("rb_wr",   bus.mem_MemWrite, 0);
      chk("rb_rd",   bus.mem_MemRead,  0);
      chk("rb_addr", bus.mem_addr,     0);
      chk("rb_rdy1", bus.m1_ready,     0);
      chk("rb_terr", bus.timeout_err,  0);
      tick();
      chk("rb_next_rd",   bus.mem_MemRead,  1);
      chk("rb_next_addr", bus.mem_addr,     32'h10);
      chk("rb_next_rdy1", bus.m1_ready,     0);
      drop_all();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
